// File: rtl/multi_digit_display.sv
// Time-multiplexed seven-segment driver with a guard-blanked slot per digit and frame-synchronous updates.
// Optional build macro LEADING_ZERO_BLANK_EN: blank leading zero digits (digit 0 is always shown).
module multi_digit_display #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 24000,
  parameter int GUARD_CYCLES = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digit_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(N_DIGITS);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt, cnt_next;
  logic [IW-1:0]         idx, idx_next;
  logic                  wrap, last_idx;
  logic [4*N_DIGITS-1:0] disp_digits, pend_digits;
  logic [N_DIGITS-1:0]   disp_dp, pend_dp;
  logic [3:0]            cur_digit;
  logic                  cur_dp;
  logic [N_DIGITS-1:0]   cur_an;
  logic [6:0]            cur_seg, enc_seg;
  logic                  cur_blank;

  assign wrap     = (cnt == CW'(REFRESH_DIV - 1));
  assign last_idx = (idx == IW'(N_DIGITS - 1));

  always_comb begin
    cnt_next = wrap ? '0 : cnt + 1'b1;
    idx_next = idx;
    if (wrap) idx_next = last_idx ? '0 : idx + 1'b1;
  end

  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_an    = '1;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_digit = disp_digits[4*i +: 4];
        cur_dp    = disp_dp[i];
        cur_an[i] = 1'b0;
      end
    end
  end

  always_comb begin
    case (cur_digit)
      4'h0: enc_seg = 7'b1000000;
      4'h1: enc_seg = 7'b1111001;
      4'h2: enc_seg = 7'b0100100;
      4'h3: enc_seg = 7'b0110000;
      4'h4: enc_seg = 7'b0011001;
      4'h5: enc_seg = 7'b0010010;
      4'h6: enc_seg = 7'b0000010;
      4'h7: enc_seg = 7'b1111000;
      4'h8: enc_seg = 7'b0000000;
      4'h9: enc_seg = 7'b0010000;
      4'hA: enc_seg = 7'b0001000;
      4'hB: enc_seg = 7'b0000011;
      4'hC: enc_seg = 7'b1000110;
      4'hD: enc_seg = 7'b0100001;
      4'hE: enc_seg = 7'b0000110;
      default: enc_seg = 7'b0001110;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // zero_run[i]: digit i and every digit above it are zero with no decimal point
  logic [N_DIGITS-1:0] zero_run;
  always_comb begin
    zero_run = '0;
    zero_run[N_DIGITS-1] = (disp_digits[4*(N_DIGITS-1) +: 4] == 4'h0) && !disp_dp[N_DIGITS-1];
    for (int unsigned k = 1; k < N_DIGITS; k++) begin
      zero_run[N_DIGITS-1-k] = zero_run[N_DIGITS-k]
                             && (disp_digits[4*(N_DIGITS-1-k) +: 4] == 4'h0)
                             && !disp_dp[N_DIGITS-1-k];
    end
    cur_blank = 1'b0;
    for (int unsigned i = 1; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) cur_blank = zero_run[i];
    end
  end
`else
  assign cur_blank = 1'b0;
`endif

  assign cur_seg = cur_blank ? 7'h7F : enc_seg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= '0;
      state       <= BLANK;
      an          <= '1;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      disp_digits <= '0;
      disp_dp     <= '0;
      pend_digits <= '0;
      pend_dp     <= '0;
      pending     <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      cnt <= cnt_next;
      idx <= idx_next;

      case (state)
        BLANK: if (cnt_next == CW'(GUARD_CYCLES)) state <= DRIVE;
        DRIVE: if (wrap) state <= BLANK;
        default: state <= BLANK;
      endcase

      // Outputs follow the state one cycle late; idx still names the slot that state belongs to.
      if (state == DRIVE) begin
        an  <= cur_an;
        seg <= cur_seg;
        dp  <= ~cur_dp;
      end else begin
        an  <= '1;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end

      frame_done <= (cnt_next == CW'(REFRESH_DIV - 1)) && (idx_next == IW'(N_DIGITS - 1));

      // Display only changes at the end of the last digit's slot so a frame never mixes values.
      if (frame_done) begin
        if (load) begin
          disp_digits <= digit_in;
          disp_dp     <= dp_in;
        end else if (pending) begin
          disp_digits <= pend_digits;
          disp_dp     <= pend_dp;
        end
        pending <= 1'b0;
      end else if (load) begin
        pend_digits <= digit_in;
        pend_dp     <= dp_in;
        pending     <= 1'b1;
      end
    end
  end

endmodule

// File: doc/multi_digit_display.md
MULTI_DIGIT_DISPLAY -- requirements
Module: multi_digit_display

Interface
REQ-001 The block SHALL have parameter N_DIGITS, default 4, number of multiplexed seven-segment digits (range 2..8).
REQ-002 The block SHALL have parameter REFRESH_DIV, default 24000, clk cycles per digit slot (2 kHz per digit at 48 MHz).
REQ-003 The block SHALL have parameter GUARD_CYCLES, default 48, blanking cycles at the start of each slot; legal range 1..REFRESH_DIV-1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; one clock, all logic on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: the reset, synchronous and active-high.
REQ-006 The block SHALL have port digit_in, input, 4*N_DIGITS bits: hex digit values; digit i occupies bits [4i+3:4i], digit 0 rightmost.
REQ-007 The block SHALL have port dp_in, input, N_DIGITS bits: decimal point request per digit, 1 = lit.
REQ-008 The block SHALL have port load, input, 1 bit: single-cycle request to capture digit_in/dp_in.
REQ-009 The block SHALL have port seg, output, 7 bits: {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 The block SHALL have port dp, output, 1 bit: decimal point, active-low, registered.
REQ-011 The block SHALL have port an, output, N_DIGITS bits: digit enables, active-low, at most one low at any time, registered.
REQ-012 The block SHALL have port pending, output, 1 bit: high while a captured value awaits the frame boundary.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when digit N_DIGITS-1's slot ends.

Function
REQ-014 The slot counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap the digit index SHALL advance by one, with N_DIGITS-1 wrapping to 0.
REQ-015 The FSM SHALL have two states:
- BLANK: slot counter < GUARD_CYCLES; all an high, seg 7'h7F, dp 1.
- DRIVE: remaining cycles of the slot; an[index] low only, seg/dp from the display register.
REQ-016 BLANK SHALL change to DRIVE when the counter reaches GUARD_CYCLES, and DRIVE SHALL change to BLANK on counter wrap.
REQ-017 Outputs SHALL lag the FSM state by exactly one cycle (registered outputs).
REQ-018 Segment encoding SHALL be standard hex 0-F, for example 0 -> 1000000, 1 -> 1111001, 8 -> 0000000, F -> 0001110.
REQ-019 A load pulse SHALL copy digit_in/dp_in into a pending register and set pending on the next cycle.
REQ-020 A later load before the boundary SHALL overwrite the pending value (last load wins).
REQ-021 At the frame boundary (frame_done cycle), if pending is set, the display register SHALL take the pending value and pending SHALL clear, so no frame mixes old and new digits.
REQ-022 If load coincides with the frame boundary, the display register SHALL take digit_in/dp_in directly and pending SHALL remain 0.
REQ-023 Changes to digit_in/dp_in without load SHALL have no effect on the display.

Reset
REQ-024 While reset is high, the block SHALL hold the slot counter at 0, index at 0, state BLANK, an all 1, seg 7'h7F, dp 1, display and pending registers at 0, pending 0, and frame_done 0.
REQ-025 Reset asserted mid-slot or mid-pending SHALL discard the pending value and return to the REQ-024 state on the next edge.
REQ-026 After reset deasserts, an[0] SHALL first go low GUARD_CYCLES+1 cycles later.

Configuration
REQ-027 With macro LEADING_ZERO_BLANK_EN defined, a digit i>0 SHALL be blanked (seg 7'h7F, dp still from dp_in) when it and all higher digits are 0 and none of them has dp set; digit 0 SHALL never be blanked, and the anode SHALL still assert.
REQ-028 Without LEADING_ZERO_BLANK_EN, every digit SHALL be displayed as encoded, and the block SHALL contain no suppression logic.

Verification (N_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2)
REQ-029 Reset-release test: reset for 3 cycles, then release -> an=1111 for cycles 1-2, an=1110 with seg=1000000 in cycles 3-8, then an=1101.
REQ-030 Load-and-scan test: load digit_in=16'h1A8F mid-frame -> pending=1 until frame_done; the next frame shows seg 0001110, 0000000, 0001000, 1111001 on an 1110, 1101, 1011, 0111.
REQ-031 Coincident-load test: load 16'h0005 on the frame_done cycle -> pending stays 0 and the next digit-0 slot shows seg=0010010.
REQ-032 Overwrite test: load 16'h1111, then 16'h2222 in the same frame -> only 2222 is displayed; 1111 never appears.
REQ-033 Mid-operation reset test: reset during a DRIVE with pending=1 -> the next cycle shows an=1111 and pending=0, and the display is back to 0000.
REQ-034 Leading-zero test (LEADING_ZERO_BLANK_EN defined): load 16'h0070 -> digits 3 and 2 show seg=1111111 with their anodes low; digit 1 shows 1111000 and digit 0 shows 1000000.
